// File: rtl/bids22_bidder.sv
// bids22_bidder: bidder-side agent turning local requests into controller strobes and tracking balance.
module bids22_bidder #(
  parameter int unsigned BID_COST = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bal_load,
  input  logic [31:0] bal_data,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_amt,
  input  logic        req_retract,
  output logic        bid,
  output logic [15:0] bidAmt,
  output logic        retract,
  input  logic        ack,
  input  logic [1:0]  err,
  input  logic        win,
  input  logic        roundOver,
  input  logic [31:0] maxBid,
  output logic        stat_valid,
  output logic [2:0]  stat_code,
  output logic [31:0] est_balance,
  output logic [15:0] cur_bid,
  output logic        result_valid,
  output logic        result_win,
  output logic [31:0] result_price
);
  typedef enum logic [1:0] {IDLE, ISSUE, RETRACT} state_t;
  state_t state, next_state;
  logic accept, nsf, charge, local_nsf;
  logic [32:0] need, bal_next;
  logic [2:0] issue_code;
  always_comb begin
    accept = req_valid && req_ready;
    need = {1'b0, req_amt} + 33'(BID_COST);
    nsf = need > {1'b0, est_balance};
    local_nsf = accept && !req_retract && nsf;
    next_state = (state == IDLE && accept) ? (req_retract ? RETRACT : (nsf ? IDLE : ISSUE)) : IDLE;
    issue_code = ack ? 3'b001 : err == 2'b10 ? 3'b011 : err == 2'b01 ? 3'b010 : err == 2'b11 ? 3'b100 : 3'b111;
    charge = state == ISSUE && (ack || err == 2'b10 || err == 2'b00);
    // 33-bit difference: a set top bit means the balance went negative and saturates to 0
    bal_next = {1'b0, est_balance} - (charge ? 33'(BID_COST) : 33'd0)
             - ((roundOver && win) ? {1'b0, maxBid} : 33'd0);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      bid          <= 1'b0;
      bidAmt       <= '0;
      retract      <= 1'b0;
      stat_valid   <= 1'b0;
      stat_code    <= '0;
      est_balance  <= '0;
      cur_bid      <= '0;
      result_valid <= 1'b0;
      result_win   <= 1'b0;
      result_price <= '0;
    end else begin
      state      <= next_state;
      req_ready  <= next_state == IDLE;
      bid        <= next_state == ISSUE;
      retract    <= next_state == RETRACT;
      if (accept && !req_retract && !nsf) bidAmt <= req_amt;
      stat_valid <= local_nsf || state != IDLE;
      stat_code  <= state == ISSUE ? issue_code :
                    state == RETRACT ? (err == 2'b01 ? 3'b010 : 3'b110) :
                    local_nsf ? 3'b101 : 3'b000;
      est_balance <= bal_load ? bal_data : (bal_next[32] ? 32'd0 : bal_next[31:0]);
      cur_bid <= roundOver ? 16'd0 :
                 (state == ISSUE && ack) ? bidAmt :
                 (state == RETRACT && err != 2'b01) ? 16'd0 : cur_bid;
      result_valid <= roundOver;
      if (roundOver) begin
        result_win   <= win;
        result_price <= maxBid;
      end
    end
  end
endmodule
